wave_gen_dds: RTL

- Phase-accumulator (DDS) test-tone generator; the transmit-side counterpart of the frequency measurement path.
- Accepts a frequency request in integer kHz, 1-100, the same code range that the measurement block reports.
- Emits 10-bit offset-binary samples for the DAC, or for loop-back into the ADC-side measurement chain.
- Used for closed-loop self-test of freq/freq_valid and for bench signal stimulus.

---
 rtl/wave_pkg.sv | 19 +
 rtl/sine_qlut.sv | 43 ++++
 rtl/wave_gen_dds.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared encodings and constants for the DDS test-tone generator and the
// frequency measurement path.
package wave_pkg;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam int unsigned F_MIN  = 1;
  localparam int unsigned F_MAX  = 100;
  // round(1e3 * 2^32 / 50e6): phase step per kHz at 50 MHz
  localparam int unsigned K_TUNE = 85899;

  localparam logic [9:0] DAC_MIDSCALE = 10'd512;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} dds_state_e;

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine magnitude ROM with registered read. Entry i holds
// round(511*sin((i+0.5)*pi/(2*DEPTH))), built at elaboration in fixed point.
module sine_qlut #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [8:0]    mag
);

  localparam int     DEPTH  = 1 << AW;
  localparam longint PI_Q30 = 64'sd3373259426;

  // Taylor series to x^9 in Q30; half-sample offset makes the quadrant
  // mirror exactly symmetric.
  function automatic logic [DEPTH*9-1:0] build_table();
    logic [DEPTH*9-1:0] t;
    longint x, x2, term, s, m;
    t = '0;
    for (int i = 0; i < DEPTH; i++) begin
      x    = (longint'(2 * i + 1) * PI_Q30) / longint'(4 * DEPTH);
      x2   = (x * x) >>> 30;
      s    = x;
      term = x;
      term = -((term * x2) >>> 30) / 6;  s = s + term;
      term = -((term * x2) >>> 30) / 20; s = s + term;
      term = -((term * x2) >>> 30) / 42; s = s + term;
      term = -((term * x2) >>> 30) / 72; s = s + term;
      m = (511 * s + (64'sd1 <<< 29)) >>> 30;
      if (m > 511) m = 511;
      if (m < 0)   m = 0;
      t[i*9 +: 9] = m[8:0];
    end
    return t;
  endfunction

  localparam logic [DEPTH*9-1:0] TABLE = build_table();

  always_ff @(posedge clk) begin
    mag <= TABLE[int'(addr)*9 +: 9];
  end

endmodule

// File: rtl/wave_gen_dds.sv
// Phase-accumulator tone generator: frequency/waveform requests are queued
// and only take effect at phase wrap, keeping the output phase-continuous.
module wave_gen_dds #(
  parameter int          ACC_W  = 32,
  parameter int unsigned K_TUNE = wave_pkg::K_TUNE,
  parameter int unsigned F_MIN  = wave_pkg::F_MIN,
  parameter int unsigned F_MAX  = wave_pkg::F_MAX,
  parameter int          LUT_AW = 8
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] freq,
  input  logic       freq_valid,
  input  logic [1:0] wave_sel,
  output logic [9:0] dac_data,
  output logic       dac_valid,
  output logic       busy,
  output logic       freq_err
);

  wave_pkg::dds_state_e state;

  logic [ACC_W-1:0] acc, tw, pend_tw, tw_req;
  logic [ACC_W:0]   acc_sum;
  logic [1:0]       wsel, pend_wsel;
  logic             wrap, req_ok, req_go;

  assign tw_req  = ACC_W'(freq) * ACC_W'(K_TUNE);
  assign req_ok  = freq_valid &&
                   (freq == 8'd0 || (32'(freq) >= F_MIN && 32'(freq) <= F_MAX));
  assign req_go  = req_ok && freq != 8'd0;
  assign acc_sum = {1'b0, acc} + {1'b0, tw};
  assign wrap    = acc_sum[ACC_W];

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state     <= wave_pkg::ST_IDLE;
      acc       <= '0;
      tw        <= '0;
      wsel      <= wave_pkg::WAVE_SINE;
      pend_tw   <= '0;
      pend_wsel <= wave_pkg::WAVE_SINE;
      busy      <= 1'b0;
      freq_err  <= 1'b0;
    end else begin
      freq_err <= freq_valid && !req_ok;
      case (state)
        wave_pkg::ST_IDLE: begin
          if (req_go) begin
            tw    <= tw_req;
            wsel  <= wave_sel;
            state <= wave_pkg::ST_RUN;
          end
        end
        wave_pkg::ST_RUN: begin
          acc <= acc_sum[ACC_W-1:0];
          if (req_ok) begin
            pend_tw   <= tw_req;
            pend_wsel <= wave_sel;
            busy      <= 1'b1;
            state     <= wave_pkg::ST_PEND;
          end
        end
        default: begin
          acc <= acc_sum[ACC_W-1:0];
          if (req_ok) begin
            pend_tw   <= tw_req;
            pend_wsel <= wave_sel;
          end
          if (wrap) begin
            tw   <= pend_tw;
            wsel <= pend_wsel;
            if (pend_tw == '0) begin
              // Stop lands in IDLE; a request arriving on the same edge is
              // treated as a fresh start from IDLE rather than re-queued.
              acc   <= '0;
              busy  <= 1'b0;
              state <= wave_pkg::ST_IDLE;
              if (req_go) begin
                tw    <= tw_req;
                wsel  <= wave_sel;
                state <= wave_pkg::ST_RUN;
              end
            end else if (!req_ok) begin
              busy  <= 1'b0;
              state <= wave_pkg::ST_RUN;
            end
          end
        end
      endcase
    end
  end

  // Stage 1: LUT read alongside the phase/waveform it belongs to
  logic [LUT_AW-1:0] lut_addr;
  logic [8:0]        s1_mag;
  logic [9:0]        s1_p;
  logic [1:0]        s1_wsel;
  logic              s1_valid;

  assign lut_addr = acc[ACC_W-2] ? ~acc[ACC_W-3 -: LUT_AW] : acc[ACC_W-3 -: LUT_AW];

  sine_qlut #(.AW(LUT_AW)) u_lut (
    .clk  (clk_50m),
    .addr (lut_addr),
    .mag  (s1_mag)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_wsel  <= wave_pkg::WAVE_SINE;
    end else begin
      s1_valid <= state != wave_pkg::ST_IDLE;
      s1_p     <= acc[ACC_W-1 -: 10];
      s1_wsel  <= wsel;
    end
  end

  // Stage 2: waveform shaping into the output register
  logic [9:0] wave_val;

  always_comb begin
    wave_val = s1_p;
    case (s1_wsel)
      wave_pkg::WAVE_SINE:
        wave_val = s1_p[9] ? wave_pkg::DAC_MIDSCALE - {1'b0, s1_mag}
                           : wave_pkg::DAC_MIDSCALE + {1'b0, s1_mag};
      wave_pkg::WAVE_SQUARE: wave_val = s1_p[9] ? 10'd0 : 10'd1023;
      wave_pkg::WAVE_TRI:    wave_val = s1_p[9] ? ~{s1_p[8:0], 1'b0} : {s1_p[8:0], 1'b0};
      default:               wave_val = s1_p;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      dac_data  <= wave_pkg::DAC_MIDSCALE;
      dac_valid <= 1'b0;
    end else begin
      dac_data  <= s1_valid ? wave_val : wave_pkg::DAC_MIDSCALE;
      dac_valid <= s1_valid;
    end
  end

endmodule
